// File: rtl/asym_flush_fifo_pkg.sv
// Package for the asymmetric flushable FIFO.
// Holds the flush FSM state type and the default parameter values shared by
// the interface, the storage sub-module and the top level.
package asym_fifo_pkg;

    localparam int DEF_WR_W     = 4;  // write-unit width in bits
    localparam int DEF_RATIO    = 8;  // write units per read word
    localparam int DEF_DEPTH_RD = 4;  // capacity in read words
    localparam int DEF_PAD      = 0;  // fill value for unwritten units of a flush word

    typedef enum logic [1:0] {
        IDLE  = 2'd0,  // normal operation, reads need a whole word stored
        FLUSH = 2'd1,  // draining units up to the flush snapshot
        DONE  = 2'd2   // snapshot drained, waiting for flush_req to drop
    } flush_state_e;

endpackage

// File: rtl/asym_flush_fifo_if.sv
// Bus interface of asym_flush_fifo.
// Ports (slave = FIFO side):
//   wr, wr_data           write unit strobe and data
//   rd                    read-word strobe
//   flush_req, err_clr    flush request (held until flush_done), sticky-error clear
//   rd_data, rd_units     read word (oldest unit in the low bits) and its valid-unit count
//   rd_avail, flush_done  read may be issued / flush complete
//   full, empty, level    occupancy in write units
//   ovf, udf              sticky overflow / underflow
interface asym_flush_fifo_if
    import asym_fifo_pkg::*;
#(
    parameter int WR_W     = DEF_WR_W,
    parameter int RATIO    = DEF_RATIO,
    parameter int DEPTH_RD = DEF_DEPTH_RD
) ();

    localparam int RD_W    = WR_W * RATIO;
    localparam int SLOTS   = DEPTH_RD * RATIO;
    localparam int UNITS_W = $clog2(RATIO) + 1;
    localparam int LEVEL_W = $clog2(SLOTS) + 1;

    logic               wr;
    logic [WR_W-1:0]    wr_data;
    logic               rd;
    logic               flush_req;
    logic               err_clr;
    logic [RD_W-1:0]    rd_data;
    logic [UNITS_W-1:0] rd_units;
    logic               rd_avail;
    logic               flush_done;
    logic               full;
    logic               empty;
    logic [LEVEL_W-1:0] level;
    logic               ovf;
    logic               udf;

    modport master (
        output wr, wr_data, rd, flush_req, err_clr,
        input  rd_data, rd_units, rd_avail, flush_done, full, empty, level, ovf, udf
    );

    modport slave (
        input  wr, wr_data, rd, flush_req, err_clr,
        output rd_data, rd_units, rd_avail, flush_done, full, empty, level, ovf, udf
    );

endinterface

// File: rtl/asym_flush_fifo_mem.sv
// Storage for asym_flush_fifo: SLOTS x WR_W array with one write port and a
// RATIO-unit-wide combinational read port starting at raddr (wrapping).
// Ports:
//   clk    clock
//   we     write enable, waddr/wdata write address and unit
//   raddr  slot of the oldest unit to read
//   rdata  RATIO consecutive units, unit at raddr in the low bits
module asym_fifo_mem
    import asym_fifo_pkg::*;
#(
    parameter int WR_W  = DEF_WR_W,
    parameter int RATIO = DEF_RATIO,
    parameter int SLOTS = DEF_DEPTH_RD * DEF_RATIO,
    localparam int IDX_W = $clog2(SLOTS)
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [IDX_W-1:0]      waddr,
    input  logic [WR_W-1:0]       wdata,
    input  logic [IDX_W-1:0]      raddr,
    output logic [WR_W*RATIO-1:0] rdata
);

    logic [WR_W-1:0] mem [SLOTS];

    // NOTE: the array has no reset; contents only matter once written, and a
    // reset would turn the array into a large bank of resettable flops.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Read window wraps naturally because SLOTS is a power of two.
    for (genvar i = 0; i < RATIO; i++) begin : g_rd
        logic [IDX_W-1:0] addr;
        assign addr = raddr + IDX_W'(i);
        assign rdata[i*WR_W +: WR_W] = mem[addr];
    end

endmodule

// File: rtl/asym_flush_fifo.sv
// Asymmetric FIFO: WR_W-bit units in, RATIO-unit words out, with a flush that
// drains a snapshot of the stored units as a final padded partial word.
// Ports:
//   clk   clock, rising edge
//   rst   asynchronous active-low reset
//   bus   asym_flush_fifo_if.slave (write/read/flush handshake and status)
module asym_flush_fifo
    import asym_fifo_pkg::*;
#(
    parameter int              WR_W     = DEF_WR_W,
    parameter int              RATIO    = DEF_RATIO,
    parameter int              DEPTH_RD = DEF_DEPTH_RD,
    parameter logic [WR_W-1:0] PAD      = WR_W'(DEF_PAD)
) (
    input  logic             clk,
    input  logic             rst,
    asym_flush_fifo_if.slave bus
);

    localparam int RD_W    = WR_W * RATIO;
    localparam int SLOTS   = DEPTH_RD * RATIO;
    localparam int IDX_W   = $clog2(SLOTS);
    localparam int PTR_W   = IDX_W + 1;          // extra wrap bit
    localparam int UNITS_W = $clog2(RATIO) + 1;

    flush_state_e       state, state_nxt;
    logic [PTR_W-1:0]   wr_ptr, rd_ptr, flush_ptr;
    logic [PTR_W-1:0]   rd_ptr_nxt, flush_snap, level, rem;
    logic               full, wr_fire, rd_avail, rd_fire;
    logic               ovf, udf;
    logic [UNITS_W-1:0] rd_n;
    logic [RD_W-1:0]    mem_word, rd_word;

    assign level   = wr_ptr - rd_ptr;
    assign full    = (level == PTR_W'(SLOTS));
    assign wr_fire = bus.wr && !full;
    assign rem     = flush_ptr - rd_ptr;

    asym_fifo_mem #(
        .WR_W  (WR_W),
        .RATIO (RATIO),
        .SLOTS (SLOTS)
    ) u_mem (
        .clk   (clk),
        .we    (wr_fire),
        .waddr (wr_ptr[IDX_W-1:0]),
        .wdata (bus.wr_data),
        .raddr (rd_ptr[IDX_W-1:0]),
        .rdata (mem_word)
    );

    // Read availability and size: a whole word normally; while flushing, up to
    // the snapshot, which may leave a short final word.
    // NOTE: every combinational output gets a default first so no path leaves
    // it unassigned (which would infer a latch).
    always_comb begin
        rd_avail = 1'b0;
        rd_n     = UNITS_W'(RATIO);
        if (state == FLUSH) begin
            rd_avail = (rem != '0);
            if (rem < PTR_W'(RATIO)) begin
                rd_n = rem[UNITS_W-1:0];
            end
        end else begin
            rd_avail = (level >= PTR_W'(RATIO));
        end
        rd_fire    = bus.rd && rd_avail;
        rd_ptr_nxt = rd_fire ? rd_ptr + PTR_W'(rd_n) : rd_ptr;
    end

    // Units beyond rd_n belong to post-snapshot writes (or nothing) and are
    // replaced with PAD; a rejected read returns all zeros.
    always_comb begin
        rd_word = '0;
        if (rd_fire) begin
            for (int i = 0; i < RATIO; i++) begin
                rd_word[i*WR_W +: WR_W] = (UNITS_W'(i) < rd_n) ? mem_word[i*WR_W +: WR_W] : PAD;
            end
        end
    end

    // Flush FSM next state. The snapshot includes a same-cycle write, and the
    // comparison uses the post-read pointer so a same-cycle read is accounted.
    always_comb begin
        state_nxt  = state;
        flush_snap = wr_ptr + PTR_W'(wr_fire);
        case (state)
            IDLE:    if (bus.flush_req) state_nxt = (flush_snap == rd_ptr_nxt) ? DONE : FLUSH;
            FLUSH:   if (rd_ptr_nxt == flush_ptr) state_nxt = DONE;
            DONE:    if (!bus.flush_req) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            flush_ptr <= '0;
            ovf       <= 1'b0;
            udf       <= 1'b0;
        end else begin
            state  <= state_nxt;
            rd_ptr <= rd_ptr_nxt;
            if (wr_fire) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (state == IDLE && bus.flush_req) begin
                flush_ptr <= flush_snap;
            end
            // A new error in the same cycle takes priority over the clear.
            if (bus.wr && full) begin
                ovf <= 1'b1;
            end else if (bus.err_clr) begin
                ovf <= 1'b0;
            end
            if (bus.rd && !rd_avail) begin
                udf <= 1'b1;
            end else if (bus.err_clr) begin
                udf <= 1'b0;
            end
        end
    end

    assign bus.rd_data    = rd_word;
    assign bus.rd_units   = rd_fire ? rd_n : '0;
    assign bus.rd_avail   = rd_avail;
    assign bus.flush_done = (state == DONE);
    assign bus.full       = full;
    assign bus.empty      = (level == '0);
    assign bus.level      = level;
    assign bus.ovf        = ovf;
    assign bus.udf        = udf;

endmodule

// File: tb/tb_asym_flush_fifo.sv
// Self-checking bench for asym_flush_fifo (WR_W=4, RATIO=8, DEPTH_RD=4, PAD=0).
// A queue-based reference model predicts every output; directed scenarios also
// compare against literal expected words.
module tb_asym_flush_fifo;

    localparam int WR_W     = 4;
    localparam int RATIO    = 8;
    localparam int DEPTH_RD = 4;
    localparam int SLOTS    = DEPTH_RD * RATIO;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    asym_flush_fifo_if #(.WR_W(WR_W), .RATIO(RATIO), .DEPTH_RD(DEPTH_RD)) bus ();

    asym_flush_fifo #(
        .WR_W     (WR_W),
        .RATIO    (RATIO),
        .DEPTH_RD (DEPTH_RD),
        .PAD      (4'h0)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model: stored units in arrival order plus flush bookkeeping.
    logic [3:0] m_q[$];
    bit         m_flushing, m_done, m_ovf, m_udf;
    int         m_left;  // snapshot units still to be read while flushing

    // Expected and observed values of the current cycle.
    bit          e_avail, e_full, e_empty, e_done, e_ovf, e_udf;
    int          e_level;
    logic [31:0] e_data;
    logic [3:0]  e_units;
    logic        o_avail, o_full, o_empty, o_done, o_ovf, o_udf;
    logic [5:0]  o_level;
    logic [31:0] o_data;
    logic [3:0]  o_units;

    task automatic model_clear();
        m_q.delete();
        m_flushing = 0; m_done = 0; m_ovf = 0; m_udf = 0; m_left = 0;
    endtask

    task automatic drive_idle();
        bus.wr = 0; bus.wr_data = '0; bus.rd = 0; bus.flush_req = 0; bus.err_clr = 0;
    endtask

    // One clock cycle: drive inputs after the falling edge, predict and sample
    // outputs before the rising edge, then advance the model past the edge.
    task automatic step(input bit w, input logic [3:0] d, input bit r, input bit f, input bit c);
        int  sz, n;
        bit  wfire, rfire;
        @(negedge clk);
        bus.wr = w; bus.wr_data = d; bus.rd = r; bus.flush_req = f; bus.err_clr = c;
        #1;
        sz      = m_q.size();
        e_avail = m_flushing ? (m_left > 0) : (sz >= RATIO);
        n       = (m_flushing && m_left < RATIO) ? m_left : RATIO;
        e_level = sz; e_full = (sz == SLOTS); e_empty = (sz == 0);
        e_done  = m_done; e_ovf = m_ovf; e_udf = m_udf;
        rfire   = r && e_avail;
        e_data  = '0; e_units = '0;
        if (rfire) begin
            for (int i = 0; i < n; i++) e_data[i*4 +: 4] = m_q[i];
            e_units = 4'(n);
        end
        o_avail = bus.rd_avail; o_full = bus.full; o_empty = bus.empty; o_done = bus.flush_done;
        o_ovf = bus.ovf; o_udf = bus.udf; o_level = bus.level; o_data = bus.rd_data; o_units = bus.rd_units;
        // advance the model
        wfire = w && (sz < SLOTS);
        if (rfire) begin
            repeat (n) void'(m_q.pop_front());
            if (m_flushing) m_left -= n;
        end
        if (wfire) m_q.push_back(d);
        if (w && !wfire) m_ovf = 1; else if (c) m_ovf = 0;
        if (r && !e_avail) m_udf = 1; else if (c) m_udf = 0;
        if (m_done) begin
            if (!f) m_done = 0;
        end else if (m_flushing) begin
            if (m_left == 0) begin m_flushing = 0; m_done = 1; end
        end else if (f) begin
            m_left = sz + int'(wfire) - (rfire ? n : 0);
            if (m_left == 0) m_done = 1; else m_flushing = 1;
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 0;
        drive_idle();
        model_clear();
        @(negedge clk);
        rst = 1;
    endtask

    task automatic test_reset();
        drive_idle();
        rst = 0;
        model_clear();
        #12;
        n_checks++; if (bus.empty !== 1'b1) $display("FAIL reset_empty: got %b want 1", bus.empty); else n_pass++;
        n_checks++; if (bus.full !== 1'b0) $display("FAIL reset_full: got %b want 0", bus.full); else n_pass++;
        n_checks++; if (bus.level !== 6'd0) $display("FAIL reset_level: got %0d want 0", bus.level); else n_pass++;
        n_checks++; if (bus.rd_avail !== 1'b0) $display("FAIL reset_rd_avail: got %b want 0", bus.rd_avail); else n_pass++;
        n_checks++; if (bus.flush_done !== 1'b0) $display("FAIL reset_flush_done: got %b want 0", bus.flush_done); else n_pass++;
        n_checks++; if ({bus.ovf, bus.udf} !== 2'b00) $display("FAIL reset_errors: got %b want 00", {bus.ovf, bus.udf}); else n_pass++;
        n_checks++; if (bus.rd_data !== 32'h0) $display("FAIL reset_rd_data: got %h want 0", bus.rd_data); else n_pass++;
        @(negedge clk);
        rst = 1;
    endtask

    task automatic test_full_word();
        do_reset();
        for (int i = 1; i <= 8; i++) step(1, 4'(i), 0, 0, 0);
        step(0, 4'h0, 1, 0, 0);
        n_checks++; if (o_data !== 32'h87654321) $display("FAIL full_word_data: got %h want 87654321", o_data); else n_pass++;
        n_checks++; if (o_units !== 4'd8) $display("FAIL full_word_units: got %0d want 8", o_units); else n_pass++;
        step(0, 4'h0, 0, 0, 0);
        n_checks++; if (o_empty !== 1'b1) $display("FAIL full_word_empty: got %b want 1", o_empty); else n_pass++;
    endtask

    task automatic test_flush_partial();
        do_reset();
        step(1, 4'hA, 0, 0, 0);
        step(1, 4'hB, 0, 0, 0);
        step(1, 4'hC, 0, 0, 0);
        step(1, 4'hD, 0, 1, 0);  // same-cycle write joins the snapshot
        step(0, 4'h0, 1, 1, 0);
        n_checks++; if (o_data !== 32'h0000DCBA) $display("FAIL flush_partial_data: got %h want 0000dcba", o_data); else n_pass++;
        n_checks++; if (o_units !== 4'd4) $display("FAIL flush_partial_units: got %0d want 4", o_units); else n_pass++;
        step(0, 4'h0, 0, 1, 0);
        n_checks++; if (o_done !== 1'b1) $display("FAIL flush_partial_done: got %b want 1", o_done); else n_pass++;
        step(0, 4'h0, 0, 0, 0);
        step(0, 4'h0, 0, 0, 0);
        n_checks++; if (o_done !== 1'b0) $display("FAIL flush_partial_done_drop: got %b want 0", o_done); else n_pass++;
    endtask

    task automatic test_flush_multi();
        do_reset();
        for (int i = 1; i <= 10; i++) step(1, 4'(i), 0, 0, 0);
        step(0, 4'h0, 0, 1, 0);
        step(1, 4'hF, 1, 1, 0);
        n_checks++; if (o_data !== 32'h87654321) $display("FAIL flush_multi_word1: got %h want 87654321", o_data); else n_pass++;
        n_checks++; if (o_units !== 4'd8) $display("FAIL flush_multi_units1: got %0d want 8", o_units); else n_pass++;
        step(1, 4'hF, 1, 1, 0);
        n_checks++; if (o_data !== 32'h000000A9) $display("FAIL flush_multi_word2: got %h want 000000a9", o_data); else n_pass++;
        n_checks++; if (o_units !== 4'd2) $display("FAIL flush_multi_units2: got %0d want 2", o_units); else n_pass++;
        step(0, 4'h0, 0, 1, 0);
        n_checks++; if (o_done !== 1'b1) $display("FAIL flush_multi_done: got %b want 1", o_done); else n_pass++;
        n_checks++; if (o_level !== 6'd2) $display("FAIL flush_multi_level: got %0d want 2", o_level); else n_pass++;
        step(0, 4'h0, 0, 0, 0);
    endtask

    task automatic test_overflow();
        do_reset();
        for (int i = 0; i < SLOTS; i++) step(1, 4'($urandom), 0, 0, 0);
        step(0, 4'h0, 0, 0, 0);
        n_checks++; if (o_full !== 1'b1) $display("FAIL ovf_full: got %b want 1", o_full); else n_pass++;
        n_checks++; if (o_level !== 6'd32) $display("FAIL ovf_level: got %0d want 32", o_level); else n_pass++;
        step(1, 4'h5, 0, 0, 1);  // dropped write; error beats same-cycle clear
        step(0, 4'h0, 1, 0, 0);
        n_checks++; if (o_ovf !== 1'b1) $display("FAIL ovf_flag: got %b want 1", o_ovf); else n_pass++;
        n_checks++; if (o_level !== 6'd32) $display("FAIL ovf_level_kept: got %0d want 32", o_level); else n_pass++;
        n_checks++; if (o_data !== e_data) $display("FAIL ovf_read_data: got %h want %h", o_data, e_data); else n_pass++;
        step(0, 4'h0, 0, 0, 0);
        n_checks++; if (o_full !== 1'b0) $display("FAIL ovf_full_after_rd: got %b want 0", o_full); else n_pass++;
        n_checks++; if (o_level !== 6'd24) $display("FAIL ovf_level_after_rd: got %0d want 24", o_level); else n_pass++;
    endtask

    task automatic test_underflow();
        do_reset();
        step(0, 4'h0, 1, 0, 0);
        n_checks++; if (o_data !== 32'h0) $display("FAIL udf_data: got %h want 0", o_data); else n_pass++;
        n_checks++; if (o_units !== 4'd0) $display("FAIL udf_units: got %0d want 0", o_units); else n_pass++;
        step(0, 4'h0, 0, 0, 0);
        n_checks++; if (o_udf !== 1'b1) $display("FAIL udf_flag: got %b want 1", o_udf); else n_pass++;
        step(0, 4'h0, 0, 0, 1);
        step(0, 4'h0, 1, 0, 1);  // clear, then error beats a same-cycle clear
        n_checks++; if (o_udf !== 1'b0) $display("FAIL udf_cleared: got %b want 0", o_udf); else n_pass++;
        step(0, 4'h0, 0, 0, 0);
        n_checks++; if (o_udf !== 1'b1) $display("FAIL udf_wins_clear: got %b want 1", o_udf); else n_pass++;
    endtask

    task automatic test_wrap();
        do_reset();
        for (int p = 0; p < 3; p++) begin
            for (int i = 0; i < SLOTS; i++) step(1, 4'($urandom), 0, 0, 0);
            for (int k = 0; k < DEPTH_RD; k++) begin
                step(0, 4'h0, 1, 0, 0);
                n_checks++; if (o_data !== e_data) $display("FAIL wrap_data p%0d w%0d: got %h want %h", p, k, o_data, e_data); else n_pass++;
            end
        end
        step(0, 4'h0, 0, 0, 0);
        n_checks++; if ({o_ovf, o_udf} !== 2'b00) $display("FAIL wrap_errors: got %b want 00", {o_ovf, o_udf}); else n_pass++;
        n_checks++; if (o_empty !== 1'b1) $display("FAIL wrap_empty: got %b want 1", o_empty); else n_pass++;
    endtask

    task automatic test_reset_mid_flush();
        do_reset();
        for (int i = 0; i < 10; i++) step(1, 4'($urandom), 0, 0, 0);
        step(0, 4'h0, 0, 1, 0);
        step(0, 4'h0, 0, 1, 0);
        n_checks++; if ({o_avail, o_done} !== 2'b10) $display("FAIL midflush_in_flush: got %b want 10", {o_avail, o_done}); else n_pass++;
        @(negedge clk);
        drive_idle();
        #2 rst = 0;
        #1;
        n_checks++; if (bus.level !== 6'd0) $display("FAIL midflush_level: got %0d want 0", bus.level); else n_pass++;
        n_checks++; if (bus.empty !== 1'b1) $display("FAIL midflush_empty: got %b want 1", bus.empty); else n_pass++;
        n_checks++; if (bus.flush_done !== 1'b0) $display("FAIL midflush_done: got %b want 0", bus.flush_done); else n_pass++;
        model_clear();
        @(negedge clk);
        rst = 1;
        for (int i = 0; i < 3; i++) begin
            step(0, 4'h0, 0, 0, 0);
            n_checks++; if (o_done !== 1'b0) $display("FAIL midflush_no_done c%0d: got %b want 0", i, o_done); else n_pass++;
        end
    endtask

    task automatic test_random();
        bit f = 0;
        do_reset();
        for (int cyc = 0; cyc < 600; cyc++) begin
            bit w, r, c;
            w = ($urandom_range(0, 9) < 6);
            r = ($urandom_range(0, 9) < 4);
            c = ($urandom_range(0, 15) == 0);
            if (!f && $urandom_range(0, 24) == 0) f = 1;
            step(w, 4'($urandom), r, f, c);
            n_checks++; if (o_avail !== e_avail) $display("FAIL rnd_avail c%0d: got %b want %b", cyc, o_avail, e_avail); else n_pass++;
            n_checks++; if (o_level !== 6'(e_level)) $display("FAIL rnd_level c%0d: got %0d want %0d", cyc, o_level, e_level); else n_pass++;
            n_checks++; if ({o_full, o_empty} !== {e_full, e_empty}) $display("FAIL rnd_flags c%0d: got %b want %b", cyc, {o_full, o_empty}, {e_full, e_empty}); else n_pass++;
            n_checks++; if (o_done !== e_done) $display("FAIL rnd_done c%0d: got %b want %b", cyc, o_done, e_done); else n_pass++;
            n_checks++; if ({o_ovf, o_udf} !== {e_ovf, e_udf}) $display("FAIL rnd_errors c%0d: got %b want %b", cyc, {o_ovf, o_udf}, {e_ovf, e_udf}); else n_pass++;
            if (r) begin
                n_checks++; if (o_data !== e_data) $display("FAIL rnd_data c%0d: got %h want %h", cyc, o_data, e_data); else n_pass++;
                n_checks++; if (o_units !== e_units) $display("FAIL rnd_units c%0d: got %0d want %0d", cyc, o_units, e_units); else n_pass++;
            end
            if (f && o_done) f = 0;
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_full_word();
        test_flush_partial();
        test_flush_multi();
        test_overflow();
        test_underflow();
        test_wrap();
        test_reset_mid_flush();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/asym_flush_fifo.md
ASYM_FLUSH_FIFO -- requirements
Module: asym_flush_fifo

Interface
REQ-001 Parameter WR_W, 4, write-unit width in bits.
REQ-002 Parameter RATIO, 8, write units per read word; RD_W = WR_W*RATIO.
REQ-003 Parameter DEPTH_RD, 4, capacity in read words; SLOTS = DEPTH_RD*RATIO write units (128 bits by default).
REQ-004 Parameter PAD, 0, WR_W-bit fill value for unwritten units of a partial flush word.
REQ-005 One clock, clk; reset rst is asynchronous, active-low.
REQ-006 clk  input  1  clock, all flops rising-edge.
REQ-007 rst  input  1  async active-low reset.
REQ-008 wr  input  1  write-unit valid.
REQ-009 wr_data  input  WR_W  write unit.
REQ-010 rd  input  1  read-word strobe.
REQ-011 flush_req  input  1  flush request, held until flush_done seen.
REQ-012 err_clr  input  1  clears sticky error flags.
REQ-013 rd_data  output  RD_W  read word, oldest unit in bits [WR_W-1:0].
REQ-014 rd_units  output  $clog2(RATIO)+1  number of valid (non-pad) units in rd_data.
REQ-015 rd_avail  output  1  a read may be issued this cycle.
REQ-016 flush_done  output  1  flush complete.
REQ-017 full, empty  output  1 each  occupancy flags.
REQ-018 level  output  $clog2(SLOTS)+1  stored units.
REQ-019 ovf, udf  output  1 each  sticky overflow / underflow.

Function
REQ-020 Storage SLOTS x WR_W; wr_ptr/rd_ptr carry one wrap bit; level = wr_ptr - rd_ptr; full = (level==SLOTS); empty = (level==0).
REQ-021 wr && !full stores wr_data, wr_ptr+1; wr && full drops data, sets ovf.
REQ-022 Flush FSM states IDLE, FLUSH, DONE; reset to IDLE.
REQ-023 IDLE and flush_req: snapshot flush_ptr = wr_ptr + (wr && !full), so same-cycle write is flushed; -> DONE if flush_ptr==rd_ptr, else -> FLUSH.
REQ-024 Normal read (IDLE/DONE): rd_avail = level>=RATIO; rd returns units rd_ptr..rd_ptr+RATIO-1 combinationally in the same cycle, rd_units=RATIO, rd_ptr+=RATIO.
REQ-025 FLUSH: rem = flush_ptr - rd_ptr; rd_avail = rem>0; rem>=RATIO gives full word as REQ-024; rem<RATIO gives rem units plus PAD in upper units, rd_units=rem, rd_ptr=flush_ptr.
REQ-026 Units written after the snapshot never appear in a flush word; after a padded read they start a fresh word.
REQ-027 FLUSH -> DONE on the cycle rd_ptr reaches flush_ptr (registered transition).
REQ-028 flush_done = (state==DONE); DONE -> IDLE when flush_req low.
REQ-029 rd while !rd_avail: no pointer change, rd_data=0, rd_units=0, udf set.
REQ-030 Simultaneous wr and rd: both take effect; full/level use registered pointers.
REQ-031 err_clr clears ovf/udf; a same-cycle error wins over err_clr.

Reset
REQ-032 rst low: pointers, level, flush_ptr 0; state IDLE; empty=1, full=0, rd_avail=0, flush_done=0, ovf=udf=0, rd_data=0.
REQ-033 Reset mid-flush abandons the flush; no flush_done issued.
REQ-034 Storage array is not reset; contents are don't-care until written.

Structure
REQ-035 Package asym_fifo_pkg holds the flush state enum typedef and default parameter constants.
REQ-036 Sub-module asym_fifo_mem: SLOTS x WR_W array, one write port, RATIO-wide combinational read port.

Verification (WR_W=4, RATIO=8, DEPTH_RD=4, PAD=0)
REQ-037 Write 1..8, rd -> rd_data=0x87654321 same cycle, rd_units=8, empty=1 next cycle.
REQ-038 Write A,B,C; flush_req with same-cycle wr D -> rd gives 0x0000DCBA, rd_units=4; flush_done=1 next cycle; drops after flush_req low.
REQ-039 10 units stored, flush while writing F each cycle -> word 1 = units 0..7, word 2 = units 8..9 plus pad, rd_units=2; no F in flush words.
REQ-040 32 writes -> full=1, level=32; 33rd write dropped, ovf=1; one rd -> full=0, level=24.
REQ-041 rst low during FLUSH -> IDLE, empty=1, level=0, flush_done=0.
REQ-042 Three passes of 32-write/4-read -> pointer wrap, data order preserved, no ovf/udf.
